// File: rtl/conv1_tile_scheduler.sv
// Tile scheduler for the conv1 im2col GEMM on an SA_N x SA_N systolic array.
// Walks n/m/k tiles and issues LOAD_W, LOAD_X, COMPUTE and WRITEBACK commands over a valid/ready bus.
module conv1_tile_scheduler #(
    parameter int M    = 3136,
    parameter int K    = 363,
    parameter int N    = 96,
    parameter int SA_N = 64,
    parameter int MW   = $clog2(M + 1),
    parameter int KW   = $clog2(K + 1),
    parameter int NW   = $clog2(N + 1)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [1:0]    cmd_op,
    output logic [MW-1:0] cmd_m_base,
    output logic [KW-1:0] cmd_k_base,
    output logic [NW-1:0] cmd_n_base,
    output logic [MW-1:0] cmd_rows,
    output logic [KW-1:0] cmd_depth,
    output logic [NW-1:0] cmd_cols,
    output logic          cmd_acc_clear,
    input  logic          op_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;
    typedef enum logic [1:0] {
        OP_LOAD_W    = 2'd0,
        OP_LOAD_X    = 2'd1,
        OP_COMPUTE   = 2'd2,
        OP_WRITEBACK = 2'd3
    } op_t;

    localparam logic [MW-1:0] M_L  = MW'(M);
    localparam logic [KW-1:0] K_L  = KW'(K);
    localparam logic [NW-1:0] N_L  = NW'(N);
    localparam logic [MW-1:0] SA_M = MW'(SA_N);
    localparam logic [KW-1:0] SA_K = KW'(SA_N);
    localparam logic [NW-1:0] SA_C = NW'(SA_N);

    state_t        state, state_nxt;
    op_t           op, op_nxt;
    logic [MW-1:0] m_base, m_base_nxt;
    logic [KW-1:0] k_base, k_base_nxt;
    logic [NW-1:0] n_base, n_base_nxt;
    logic          m_last, k_last, n_last;
    logic [MW-1:0] m_rem, rows_raw;
    logic [KW-1:0] k_rem, depth_raw;
    logic [NW-1:0] n_rem, cols_raw;

    // Compared in int so the step past the last tile cannot wrap the narrow counters.
    assign m_last = (int'(m_base) + SA_N) >= M;
    assign k_last = (int'(k_base) + SA_N) >= K;
    assign n_last = (int'(n_base) + SA_N) >= N;

    assign m_rem     = M_L - m_base;
    assign k_rem     = K_L - k_base;
    assign n_rem     = N_L - n_base;
    assign rows_raw  = (m_rem < SA_M) ? m_rem : SA_M;
    assign depth_raw = (k_rem < SA_K) ? k_rem : SA_K;
    assign cols_raw  = (n_rem < SA_C) ? n_rem : SA_C;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            op     <= OP_LOAD_W;
            m_base <= '0;
            k_base <= '0;
            n_base <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state  <= state_nxt;
            op     <= op_nxt;
            m_base <= m_base_nxt;
            k_base <= k_base_nxt;
            n_base <= n_base_nxt;
        end
    end

    always_comb begin
        // NOTE: hold-current defaults first so no path leaves a signal unassigned (no latches).
        state_nxt  = state;
        op_nxt     = op;
        m_base_nxt = m_base;
        k_base_nxt = k_base;
        n_base_nxt = n_base;
        unique case (state)
            IDLE:  if (start) state_nxt = ISSUE;
            ISSUE: if (cmd_ready) state_nxt = WAIT;
            WAIT: begin
                if (op_done) begin
                    state_nxt = ISSUE;
                    unique case (op)
                        OP_LOAD_W: op_nxt = OP_LOAD_X;
                        OP_LOAD_X: op_nxt = OP_COMPUTE;
                        OP_COMPUTE: begin
                            if (k_last) begin
                                op_nxt = OP_WRITEBACK;
                            end else begin
                                op_nxt     = OP_LOAD_W;
                                k_base_nxt = k_base + SA_K;
                            end
                        end
                        OP_WRITEBACK: begin
                            op_nxt     = OP_LOAD_W;
                            k_base_nxt = '0;
                            if (!m_last) begin
                                m_base_nxt = m_base + SA_M;
                            end else begin
                                m_base_nxt = '0;
                                if (!n_last) begin
                                    n_base_nxt = n_base + SA_C;
                                end else begin
                                    n_base_nxt = '0;
                                    state_nxt  = FIN;
                                end
                            end
                        end
                    endcase
                end
            end
            FIN:   state_nxt = IDLE;
        endcase
    end

    assign busy          = (state == ISSUE) || (state == WAIT);
    assign done          = (state == FIN);
    assign cmd_valid     = (state == ISSUE);
    assign cmd_op        = op;
    assign cmd_m_base    = m_base;
    assign cmd_k_base    = k_base;
    assign cmd_n_base    = n_base;
    // Extents read zero outside a layer so idle outputs match the reset values.
    assign cmd_rows      = busy ? rows_raw : '0;
    assign cmd_depth     = busy ? depth_raw : '0;
    assign cmd_cols      = busy ? cols_raw : '0;
    assign cmd_acc_clear = busy && (op == OP_COMPUTE) && (k_base == '0);

endmodule

// File: tb/tb_conv1_tile_scheduler.sv
// Directed bench for conv1_tile_scheduler: instant, stalled/noisy and aborted layers
// checked against an independently built command list and hand-computed tile clamps.
module tb_conv1_tile_scheduler;

    localparam int M     = 3136;
    localparam int K     = 363;
    localparam int N     = 96;
    localparam int SA_N  = 64;
    localparam int TOTAL = 1862;

    logic        CLK = 1'b0;
    logic        nRST, start, cmd_ready, op_done;
    logic        busy, done, cmd_valid, cmd_acc_clear;
    logic [1:0]  cmd_op;
    logic [11:0] cmd_m_base, cmd_rows;
    logic [8:0]  cmd_k_base, cmd_depth;
    logic [6:0]  cmd_n_base, cmd_cols;

    conv1_tile_scheduler dut (
        .CLK(CLK), .nRST(nRST), .start(start), .busy(busy), .done(done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_m_base(cmd_m_base), .cmd_k_base(cmd_k_base), .cmd_n_base(cmd_n_base),
        .cmd_rows(cmd_rows), .cmd_depth(cmd_depth), .cmd_cols(cmd_cols),
        .cmd_acc_clear(cmd_acc_clear), .op_done(op_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int op; int m; int k; int n; int rows; int depth; int cols; int acc;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t act_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Fields a command does not use are zeroed on both sides before comparing.
    function automatic logic [63:0] pack(input cmd_t c, input int mask_op);
        logic use_m = (mask_op != 0);
        logic use_k = (mask_op != 3);
        logic use_n = (mask_op != 1);
        logic use_a = (mask_op == 2);
        return {5'd0, 2'(c.op),
                use_m ? 12'(c.m) : 12'd0, use_k ? 9'(c.k) : 9'd0, use_n ? 7'(c.n) : 7'd0,
                use_m ? 12'(c.rows) : 12'd0, use_k ? 9'(c.depth) : 9'd0,
                use_n ? 7'(c.cols) : 7'd0, use_a ? 1'(c.acc) : 1'b0};
    endfunction

    function automatic cmd_t sample();
        cmd_t c;
        c.op = int'(cmd_op); c.m = int'(cmd_m_base); c.k = int'(cmd_k_base);
        c.n = int'(cmd_n_base); c.rows = int'(cmd_rows); c.depth = int'(cmd_depth);
        c.cols = int'(cmd_cols); c.acc = int'(cmd_acc_clear);
        return c;
    endfunction

    function automatic void build_expected();
        exp_q.delete();
        for (int n = 0; n < N; n += SA_N) begin
            for (int m = 0; m < M; m += SA_N) begin
                for (int k = 0; k < K; k += SA_N) begin
                    exp_q.push_back('{0, m, k, n, min2(SA_N, M - m), min2(SA_N, K - k), min2(SA_N, N - n), 0});
                    exp_q.push_back('{1, m, k, n, min2(SA_N, M - m), min2(SA_N, K - k), min2(SA_N, N - n), 0});
                    exp_q.push_back('{2, m, k, n, min2(SA_N, M - m), min2(SA_N, K - k), min2(SA_N, N - n),
                                      (k == 0) ? 1 : 0});
                end
                exp_q.push_back('{3, m, 0, n, min2(SA_N, M - m), 0, min2(SA_N, N - n), 0});
            end
        end
    endfunction

    task automatic check_reset_outputs(input string name);
        check({name, ":rst_busy"}, busy, 0);
        check({name, ":rst_done"}, done, 0);
        check({name, ":rst_valid"}, cmd_valid, 0);
        check({name, ":rst_acc"}, cmd_acc_clear, 0);
        check({name, ":rst_op"}, cmd_op, 0);
        check({name, ":rst_bases"}, {cmd_m_base, cmd_k_base, cmd_n_base}, 0);
        check({name, ":rst_extents"}, {cmd_rows, cmd_depth, cmd_cols}, 0);
    endtask

    // Responder: drives cmd_ready/op_done at negedges and scoreboards every handshake.
    task automatic run_layer(input string name, input int stall_max, input bit noisy, input int abort_at,
                             output int hs_n, output int wb_n, output int done_n);
        int          stall, extra;
        bit          pending, abort_now, finished, have_hold, prev_busy;
        logic [63:0] hold;
        cmd_t        a, e;
        hs_n = 0; wb_n = 0; done_n = 0; extra = 0;
        pending = 0; abort_now = 0; finished = 0; have_hold = 0;
        act_q.delete();
        stall = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
        @(negedge CLK);
        start = 1'b1; cmd_ready = (stall_max == 0); op_done = 1'b0;
        @(negedge CLK);
        start = 1'b0;
        check({name, ":busy_on_start"}, busy, 1);
        prev_busy = 1'b1;
        for (int cyc = 0; cyc < 30000 && !finished; cyc++) begin
            op_done = 1'b0;
            start   = noisy && (cyc == 40 || cyc == 2501);
            if (abort_now) begin
                check({name, ":pre_abort_busy"}, busy, 1);
                check({name, ":pre_abort_valid"}, cmd_valid, 0);
                check({name, ":pre_abort_op"}, cmd_op, 2);
                check({name, ":pre_abort_m"}, cmd_m_base, 640);
                #2 nRST = 1'b0;
                #1 check_reset_outputs({name, ":async"});
                @(negedge CLK);
                check({name, ":abort_done"}, done, 0);
                nRST = 1'b1;
                finished = 1'b1;
                break;
            end
            if (pending) begin
                op_done = 1'b1;
                pending = 1'b0;
            end
            if (done) begin
                done_n++;
                check({name, ":busy_at_done"}, busy, 0);
                check({name, ":busy_before_done"}, prev_busy, 1);
                finished = 1'b1;
            end
            prev_busy = busy;
            if (cmd_valid) begin
                a = sample();
                if (have_hold) check({name, ":held_fields"}, pack(a, 2), hold);
                else begin
                    hold = pack(a, 2);
                    have_hold = 1'b1;
                end
                if (stall > 0) begin
                    stall--;
                    cmd_ready = 1'b0;
                    if (noisy) op_done = 1'($urandom_range(1, 0));
                end else begin
                    cmd_ready = 1'b1;
                    if (hs_n < exp_q.size()) begin
                        e = exp_q[hs_n];
                        check($sformatf("%s:cmd%0d", name, hs_n), pack(a, e.op), pack(e, e.op));
                    end else begin
                        check({name, ":extra_cmd"}, hs_n, exp_q.size());
                    end
                    act_q.push_back(a);
                    if (a.op == 3) wb_n++;
                    hs_n++;
                    pending   = 1'b1;
                    have_hold = 1'b0;
                    stall     = (stall_max > 0) ? int'($urandom_range(stall_max, 0)) : 0;
                    abort_now = (hs_n == abort_at);
                end
            end else begin
                cmd_ready = (stall_max == 0) ? 1'b1 : 1'($urandom_range(1, 0));
            end
            @(negedge CLK);
        end
        start = 1'b0; op_done = 1'b0; cmd_ready = 1'b0;
        check({name, ":finished"}, finished, 1);
        repeat (4) begin
            @(negedge CLK);
            if (done) extra++;
        end
        check({name, ":no_extra_done"}, extra, 0);
        check({name, ":idle_busy"}, busy, 0);
    endtask

    initial begin
        int hs, wb, dn;
        build_expected();
        nRST = 1'b0; start = 1'b0; cmd_ready = 1'b0; op_done = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge CLK);
        nRST = 1'b1;
        // Stray op_done and ready while idle must not start anything.
        op_done = 1'b1; cmd_ready = 1'b1;
        @(negedge CLK);
        op_done = 1'b0;
        check("idle_stray_busy", busy, 0);

        run_layer("instant", 0, 1'b0, -1, hs, wb, dn);
        check("instant:handshakes", hs, TOTAL);
        check("instant:writebacks", wb, 98);
        check("instant:done_pulses", dn, 1);
        check("first_op", act_q[0].op, 0);
        check("first_w_k_n", {act_q[0].k, act_q[0].n}, 0);
        check("first_w_depth_cols", {act_q[0].depth, act_q[0].cols}, {32'd64, 32'd64});
        check("first_x_op_rows", {act_q[1].op, act_q[1].m, act_q[1].rows}, {32'd1, 32'd0, 32'd64});
        check("first_compute_clear", {act_q[2].op, act_q[2].acc}, {32'd2, 32'd1});
        check("second_compute_accum", {act_q[5].op, act_q[5].k, act_q[5].acc}, {32'd2, 32'd64, 32'd0});
        check("last_slice_base", {act_q[15].op, act_q[15].k}, {32'd0, 32'd320});
        check("last_slice_depth", act_q[15].depth, 43);
        check("final_wb_op", act_q[TOTAL-1].op, 3);
        check("final_wb_bases", {act_q[TOTAL-1].m, act_q[TOTAL-1].n}, {32'd3072, 32'd64});
        check("final_wb_extents", {act_q[TOTAL-1].rows, act_q[TOTAL-1].cols}, {32'd64, 32'd32});

        run_layer("stall", 5, 1'b1, -1, hs, wb, dn);
        check("stall:handshakes", hs, TOTAL);
        check("stall:writebacks", wb, 98);
        check("stall:done_pulses", dn, 1);

        run_layer("abort", 0, 1'b0, 10 * 19 + 3, hs, wb, dn);
        check("abort:handshakes", hs, 193);
        check("abort:done_pulses", dn, 0);

        run_layer("restart", 0, 1'b0, -1, hs, wb, dn);
        check("restart:first_bases", {act_q[0].m, act_q[0].k, act_q[0].n}, 0);
        check("restart:handshakes", hs, TOTAL);
        check("restart:done_pulses", dn, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
